ram_dma: RTL and testbench
==========================

# ram_dma

Block-transfer engine on the 8-bit RAM bus: copies a run of bytes from one RAM address to another, or fills a run with a constant. It is the initiating end of the RAM's interface: it drives `abus` and `wr_en`, drives `dbus` during writes, and samples `dbus` during reads. It requests the bus from the CPU-side arbiter and proceeds only while granted.

## Interface
- `AW`, default 8: address width; addresses wrap modulo 2^AW.
- `DW`, default 8: data width.
- `clk`  in  1  single clock; all state changes on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch command; sampled on posedge while idle, ignored while `busy`.
- `mode`  in  1  0 = copy, 1 = fill; captured with `start`.
- `src`  in  AW  copy source base; captured with `start`.
- `dst`  in  AW  destination base; captured with `start`.
- `len`  in  AW  byte count; 0 = no transfer; captured with `start`.
- `fill_val`  in  DW  fill byte; captured with `start`.
- `busy`  out  1  high from the `start` edge until the edge that raises `done`.
- `done`  out  1  one-cycle completion pulse.
- `bus_req`  out  1  equals `busy`.
- `bus_gnt`  in  1  arbiter grant; bus cycles occur only while high.
- `abus`  out  AW  RAM address; 0 when not in a bus cycle.
- `wr_en`  out  1  RAM write enable; high only in granted WR cycles.
- `dbus`  inout  DW  driven with write data only when `wr_en` is 1; otherwise high-Z.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE, `start`=1:
  - Capture operands.
  - Clear the byte index `i`.
  - Set `busy`.
  - Next state: DONE if `len`=0; else RD if copy; else WR if fill.
- RD (copy only):
  - `abus`=`src`+`i`, `wr_en`=0, `dbus` released.
  - If `bus_gnt` is high, the RAM's read data is latched into the data register on the posedge and the state goes to WR.
  - If `bus_gnt` is low, the cycle is idle (`abus`=0) and the state holds; the cycle is retried.
- WR:
  - `abus`=`dst`+`i`, `wr_en`=1, `dbus`=data register (copy) or `fill_val` (fill).
  - If `bus_gnt` is high, the RAM writes on the posedge and `i` increments.
  - If that was byte `len`-1, go to DONE; otherwise go to RD (copy) or stay in WR (fill).
  - If `bus_gnt` is low: `wr_en`=0, `abus`=0, `dbus` high-Z, state holds.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE.
- Address arithmetic is modulo 2^AW. Example: `src`=0xFE, `len`=4 reads 0xFE, 0xFF, 0x00, 0x01.
- Overlap: copy runs strictly ascending, one byte read then written. With `dst` inside (`src`, `src`+`len`), the result is the byte-serial result (pattern propagation); this behaviour is required, not an error.
- `start` during `busy` or DONE has no effect, and captured operands do not change.
- `rst_n` low at any time, including mid-transfer:
  - Immediately `busy`=0, `done`=0, `wr_en`=0, `abus`=0, `dbus` high-Z.
  - State IDLE, `i`=0, data register 0.
  - Partially written destination bytes stay as written.

## Timing
- Reset values: all outputs 0, `dbus` high-Z.
- `wr_en` and `abus` are registered-state decodes, glitch-free within a cycle.
- `dbus` is driven combinationally from the `wr_en` condition, so the RAM never sees `wr_en`=1 with a floating bus.
- With `bus_gnt` held high, `start` sampled at edge 0:
  - Copy: bus cycles 1..2N; `done` high during cycle 2N+1.
  - Fill: bus cycles 1..N; `done` high during cycle N+1.
  - `len`=0: `done` high during cycle 1; no bus cycles.
- Each low-`bus_gnt` cycle adds exactly one cycle of latency. No data is lost across a grant drop between RD and WR.
- Back-to-back: `start` may be accepted in the IDLE cycle right after DONE. Minimum command spacing is `done` + 1 cycle.

## Test plan
- Fill, `dst`=0x10, `len`=4, `fill_val`=0xA5, gnt=1 -> 4 WR cycles at 0x10..0x13 with `dbus`=0xA5; `done` in cycle 5; RAM[0x10..0x13]=0xA5, RAM[0x14] unchanged.
- Copy, RAM[0x20..0x22]=01,02,03, `src`=0x20, `dst`=0x40, `len`=3 -> RD/WR alternate for 6 cycles; RAM[0x40..0x42]=01,02,03; `done` in cycle 7; `dbus` high-Z in every RD cycle.
- Wrap: copy `src`=0xFE, `dst`=0x01, `len`=3 -> reads 0xFE, 0xFF, 0x00; writes 0x01, 0x02, 0x03.
- Overlap: RAM[0x30]=0x5A, copy `src`=0x30, `dst`=0x31, `len`=4 -> RAM[0x31..0x34] all 0x5A.
- Grant stalls: copy of 2 bytes with `bus_gnt` low on cycles 2 and 4 -> total 6 bus-stage cycles; `wr_en`=0 and `abus`=0 during stalls; correct data written; `start` pulsed mid-transfer ignored.
- Reset mid-fill (`len`=8, `rst_n` low after the 3rd write) -> outputs 0 immediately; only 3 bytes written; a fresh `start` after release runs normally; `len`=0 gives `done` one cycle after `start` with no bus cycles.

Source files
------------

// File: rtl/ram_dma.sv
// ram_dma: block copy / fill engine on the 8-bit RAM bus.
// It holds a captured command and walks a byte index. Copy runs as one RD
// cycle then one WR cycle per byte; fill runs as one WR cycle per byte.
// Every bus cycle waits for bus_gnt and is simply retried while the grant is low.
module ram_dma #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic          bus_req,
  input  logic          bus_gnt,
  output logic [AW-1:0] abus,
  output logic          wr_en,
  inout  wire  [DW-1:0] dbus
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  localparam logic [AW-1:0] ONE = AW'(1);

  state_t        state;
  logic [AW-1:0] idx;
  logic [AW-1:0] src_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] len_q;
  logic          mode_q;
  logic [DW-1:0] fill_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] wdata;
  logic          last;

  // The byte being written is the final one of the run.
  assign last = (idx == (len_q - ONE));

  // Command sequencer: captures operands, steps through RD/WR, pulses DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      idx    <= '0;
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      mode_q <= 1'b0;
      fill_q <= '0;
      data_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src_q  <= src;
            dst_q  <= dst;
            len_q  <= len;
            mode_q <= mode;
            fill_q <= fill_val;
            idx    <= '0;
            if (len == '0)
              state <= S_DONE;
            else if (mode)
              state <= S_WR;
            else
              state <= S_RD;
          end
        end
        S_RD: begin
          if (bus_gnt) begin
            data_q <= dbus;
            state  <= S_WR;
          end
        end
        S_WR: begin
          if (bus_gnt) begin
            idx <= idx + ONE;
            if (last)
              state <= S_DONE;
            else if (!mode_q)
              state <= S_RD;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (state == S_RD) || (state == S_WR);
  assign done    = (state == S_DONE);
  assign bus_req = busy;
  assign wr_en   = (state == S_WR) && bus_gnt;

  // Address decode: only granted RD/WR cycles put an address on the bus.
  always_comb begin
    abus = '0;
    if (bus_gnt && (state == S_RD))
      abus = src_q + idx;
    else if (bus_gnt && (state == S_WR))
      abus = dst_q + idx;
  end

  // The data bus is driven from the same condition as wr_en, never floating while writing.
  assign wdata = mode_q ? fill_q : data_q;
  assign dbus  = wr_en ? wdata : {DW{1'bz}};

endmodule

// File: tb/tb_ram_dma.sv
// tb_ram_dma: bench for ram_dma with a behavioural RAM and a transfer model.
// The model expands each accepted command into its list of bus operations and
// keeps its own copy of memory; a negedge process compares the DUT every cycle.
module tb_ram_dma;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [7:0] src;
  logic [7:0] dst;
  logic [7:0] len;
  logic [7:0] fill_val;
  logic       busy;
  logic       done;
  logic       bus_req;
  logic       bus_gnt;
  logic [7:0] abus;
  logic       wr_en;
  wire  [7:0] dbus;

  int checks;
  int failures;

  ram_dma #(.AW(8), .DW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done), .bus_req(bus_req),
    .bus_gnt(bus_gnt), .abus(abus), .wr_en(wr_en), .dbus(dbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: reads drive the bus whenever the DMA is not writing.
  logic [7:0] ram [256];
  logic       poke_en;
  logic [7:0] poke_addr;
  logic [7:0] poke_data;

  assign dbus = wr_en ? 8'hzz : ram[abus];

  // RAM write port: bench pokes while idle, DMA writes otherwise.
  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (wr_en) ram[abus] <= dbus;
  end

  // Reference model: phase of the transfer, pending bus operations, model memory.
  typedef enum int {P_IDLE, P_ACT, P_DONE} phase_t;
  typedef struct packed {
    logic       we;
    logic       use_rd;
    logic [7:0] addr;
    logic [7:0] data;
  } op_t;

  phase_t     phase;
  op_t        ops[$];
  logic [7:0] mem_m [256];
  logic [7:0] rdval;

  // Model advance: async reset, command expansion, one op consumed per granted cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = P_IDLE;
      ops.delete();
      rdval = 8'h00;
    end else begin
      if (poke_en) mem_m[poke_addr] = poke_data;
      case (phase)
        P_IDLE: begin
          if (start) begin
            ops.delete();
            for (int k = 0; k < int'(len); k++) begin
              if (!mode) begin
                ops.push_back('{we: 1'b0, use_rd: 1'b0, addr: 8'(src + 8'(k)), data: 8'h00});
                ops.push_back('{we: 1'b1, use_rd: 1'b1, addr: 8'(dst + 8'(k)), data: 8'h00});
              end else begin
                ops.push_back('{we: 1'b1, use_rd: 1'b0, addr: 8'(dst + 8'(k)), data: fill_val});
              end
            end
            phase = (len == 8'd0) ? P_DONE : P_ACT;
          end
        end
        P_ACT: begin
          if (bus_gnt && ops.size() > 0) begin
            op_t op;
            op = ops.pop_front();
            if (!op.we) rdval = mem_m[op.addr];
            else mem_m[op.addr] = op.use_rd ? rdval : op.data;
            if (ops.size() == 0) phase = P_DONE;
          end
        end
        default: phase = P_IDLE;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    chk("busy", int'(busy), int'(phase == P_ACT));
    chk("bus_req", int'(bus_req), int'(phase == P_ACT));
    chk("done", int'(done), int'(phase == P_DONE));
    if (phase == P_ACT && bus_gnt && ops.size() > 0) begin
      chk("abus", int'(abus), int'(ops[0].addr));
      chk("wr_en", int'(wr_en), int'(ops[0].we));
      if (ops[0].we)
        chk("dbus", int'(dbus), int'(ops[0].use_rd ? rdval : ops[0].data));
    end else begin
      chk("abus_idle", int'(abus), 0);
      chk("wr_en_idle", int'(wr_en), 0);
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    poke_en = 1'b1;
    poke_addr = a;
    poke_data = d;
    @(posedge clk);
    #2;
    poke_en = 1'b0;
  endtask

  // Issue one command; cycle c runs between edge c-1 and edge c, start sampled at edge 0.
  task automatic run_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] l, input logic [7:0] f,
                         input logic [31:0] low_mask, input bit rand_gnt,
                         input int pulse_cyc, input int rst_cyc, output int done_cyc);
    int c;
    bit fin;
    mode = m; src = s; dst = d; len = l; fill_val = f;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    c = 1;
    fin = 1'b0;
    done_cyc = -1;
    while (!fin) begin
      if (rand_gnt) bus_gnt = ($urandom_range(0, 3) != 0);
      else bus_gnt = (c < 32) ? !low_mask[c] : 1'b1;
      if (c == pulse_cyc) begin
        start = 1'b1; mode = ~m; src = 8'hAA; dst = 8'h0F; len = 8'h05; fill_val = 8'hEE;
      end
      if (c == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_abus", int'(abus), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        fin = 1'b1;
      end else begin
        @(negedge clk);
        if (done) begin
          done_cyc = c;
          fin = 1'b1;
        end else if (c > 2000) begin
          chk("timeout", c, 0);
          fin = 1'b1;
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        c++;
      end
    end
    bus_gnt = 1'b1;
  endtask

  int dc;

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
    fill_val = '0; bus_gnt = 1'b1; poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    checks = 0; failures = 0;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_abus", int'(abus), 0);
    chk("reset_wr_en", int'(wr_en), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 256; k++) poke(8'(k), 8'($urandom));

    // Fill 0x10..0x13 with 0xA5
    poke(8'h14, 8'h77);
    run_cmd(1'b1, 8'h00, 8'h10, 8'd4, 8'hA5, 32'h0, 1'b0, -1, -1, dc);
    chk("fill_done_cycle", dc, 5);
    for (int k = 0; k < 4; k++) chk("fill_data", int'(ram[8'h10 + k]), 'hA5);
    chk("fill_untouched", int'(ram[8'h14]), 'h77);

    // Copy 0x20..0x22 -> 0x40..0x42
    poke(8'h20, 8'h01); poke(8'h21, 8'h02); poke(8'h22, 8'h03);
    run_cmd(1'b0, 8'h20, 8'h40, 8'd3, 8'h00, 32'h0, 1'b0, -1, -1, dc);
    chk("copy_done_cycle", dc, 7);
    chk("copy_b0", int'(ram[8'h40]), 'h01);
    chk("copy_b1", int'(ram[8'h41]), 'h02);
    chk("copy_b2", int'(ram[8'h42]), 'h03);

    // Address wrap on the source
    poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33);
    run_cmd(1'b0, 8'hFE, 8'h01, 8'd3, 8'h00, 32'h0, 1'b0, -1, -1, dc);
    chk("wrap_done_cycle", dc, 7);
    chk("wrap_b0", int'(ram[8'h01]), 'h11);
    chk("wrap_b1", int'(ram[8'h02]), 'h22);
    chk("wrap_b2", int'(ram[8'h03]), 'h33);

    // Overlapping copy propagates the first byte
    poke(8'h30, 8'h5A);
    run_cmd(1'b0, 8'h30, 8'h31, 8'd4, 8'h00, 32'h0, 1'b0, -1, -1, dc);
    for (int k = 1; k < 5; k++) chk("overlap", int'(ram[8'h30 + k]), 'h5A);

    // Grant low on cycles 2 and 4, stray start in cycle 3
    poke(8'h70, 8'hC1); poke(8'h71, 8'hC2);
    run_cmd(1'b0, 8'h70, 8'h80, 8'd2, 8'h00, 32'h14, 1'b0, 3, -1, dc);
    chk("stall_done_cycle", dc, 7);
    chk("stall_b0", int'(ram[8'h80]), 'hC1);
    chk("stall_b1", int'(ram[8'h81]), 'hC2);

    // Reset during an 8-byte fill after the 3rd write
    poke(8'h53, 8'h33);
    run_cmd(1'b1, 8'h00, 8'h50, 8'd8, 8'hC3, 32'h0, 1'b0, -1, 4, dc);
    for (int k = 0; k < 3; k++) chk("rst_fill_written", int'(ram[8'h50 + k]), 'hC3);
    chk("rst_fill_stopped", int'(ram[8'h53]), 'h33);
    run_cmd(1'b1, 8'h00, 8'h60, 8'd2, 8'h9C, 32'h0, 1'b0, -1, -1, dc);
    chk("after_rst_done_cycle", dc, 3);
    chk("after_rst_data", int'(ram[8'h61]), 'h9C);
    run_cmd(1'b0, 8'h00, 8'h00, 8'd0, 8'h00, 32'h0, 1'b0, -1, -1, dc);
    chk("len0_done_cycle", dc, 1);

    // Randomized commands with random grant
    for (int n = 0; n < 30; n++)
      run_cmd(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 12)),
              8'($urandom), 32'h0, 1'b1, -1, -1, dc);
    for (int k = 0; k < 256; k++) chk("ram_vs_model", int'(ram[k]), int'(mem_m[k]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
